// File: rtl/led_pwm_ctrl_pkg.sv
// Shared MMIO constants and ctrl-register field layout for the LED PWM output stage.
package led_pwm_ctrl_pkg;

  localparam logic [31:0] LED_PWM_CTRL_ADDR = 32'hFFFFF064;

  localparam int DUTY_LSB     = 0;
  localparam int DUTY_W       = 8;
  localparam int BLINK_EN_BIT = 8;
  localparam int HALF_LSB     = 16;
  localparam int HALF_W       = 8;

  localparam logic [31:0] CTRL_RST  = 32'h000000FF;
  localparam logic [31:0] CTRL_MASK = 32'h00FF01FF;

  // Duty 255 means solid on, so the compare alone would leave one dark slot per period.
  function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] duty);
    if (duty == 8'd0)
      return 1'b0;
    else if (duty == 8'd255)
      return 1'b1;
    else
      return (cnt < duty);
  endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// PWM timebase: prescaler dividing clk into ticks, and an 8-bit PWM slot counter.
module led_pwm_timebase #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] pwm_cnt_o,
  output logic       period_end_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          tick;

  always_comb begin
    tick    = (presc_q == PRE_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
    cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pwm_cnt_o    = cnt_q;
  assign period_end_o = tick && (cnt_q == 8'd255);

endmodule

// File: rtl/led_pwm_ctrl.sv
// LED output stage: applies PWM brightness and optional blink to the LED register pattern.
module led_pwm_ctrl
  import led_pwm_ctrl_pkg::*;
#(
  parameter logic [31:0] CTRL_ADDR = LED_PWM_CTRL_ADDR,
  parameter int          PRESCALE  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [23:0] led_in,
  output logic [31:0] rdata,
  output logic [23:0] led_out
);

  logic [31:0] ctrl_q, ctrl_d;
  logic [7:0]  duty_act_q, duty_act_d;
  logic        blink_en_act_q, blink_en_act_d;
  logic [7:0]  half_act_q, half_act_d;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;
  logic [23:0] led_q, led_d;

  logic [7:0]  pwm_cnt;
  logic        period_end;
  logic        sel;
  logic [7:0]  half_eff;
  logic        blink_wrap;
  logic        phase_eff;
  logic        pwm_on;

  led_pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_cnt_o    (pwm_cnt),
    .period_end_o (period_end)
  );

  assign sel   = (addr == CTRL_ADDR);
  assign rdata = sel ? (ctrl_q & CTRL_MASK) : 32'h0;

  always_comb begin
    ctrl_d         = ctrl_q;
    duty_act_d     = duty_act_q;
    blink_en_act_d = blink_en_act_q;
    half_act_d     = half_act_q;
    if (we && sel)
      ctrl_d = wdata & CTRL_MASK;
    // Shadow samples the pre-write ctrl, so a write on period_end lands one period later.
    if (period_end) begin
      duty_act_d     = ctrl_q[DUTY_LSB +: DUTY_W];
      blink_en_act_d = ctrl_q[BLINK_EN_BIT];
      half_act_d     = ctrl_q[HALF_LSB +: HALF_W];
    end
  end

  always_comb begin
    half_eff    = (half_act_q == 8'd0) ? 8'd1 : half_act_q;
    blink_wrap  = ({1'b0, blink_cnt_q} + 9'd1) >= {1'b0, half_eff};
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!blink_en_act_q) begin
      blink_cnt_d = 8'd0;
      phase_d     = 1'b1;
    end else if (period_end) begin
      if (blink_wrap) begin
        blink_cnt_d = 8'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  // phase_q may still hold an off phase in the first cycle after blink is switched off.
  assign phase_eff = phase_q | ~blink_en_act_q;
  assign pwm_on    = pwm_level(pwm_cnt, duty_act_q);
  assign led_d     = (pwm_on && phase_eff) ? led_in : 24'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q         <= CTRL_RST;
      duty_act_q     <= 8'd255;
      blink_en_act_q <= 1'b0;
      half_act_q     <= 8'd0;
      blink_cnt_q    <= 8'd0;
      phase_q        <= 1'b1;
      led_q          <= 24'h0;
    end else begin
      ctrl_q         <= ctrl_d;
      duty_act_q     <= duty_act_d;
      blink_en_act_q <= blink_en_act_d;
      half_act_q     <= half_act_d;
      blink_cnt_q    <= blink_cnt_d;
      phase_q        <= phase_d;
      led_q          <= led_d;
    end
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl with PRESCALE=2 (512-cycle PWM period).
module tb_led_pwm_ctrl;

  localparam logic [31:0] CADDR = 32'hFFFFF064;
  localparam logic [23:0] ALL   = 24'hFFFFFF;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [23:0] led_in;
  logic [31:0] rdata;
  logic [23:0] led_out;

  int n_assert = 0;
  int n_fail   = 0;
  int ecnt;

  led_pwm_ctrl #(.CTRL_ADDR(CADDR), .PRESCALE(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .led_in  (led_in),
    .rdata   (rdata),
    .led_out (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release: after edge k has been sampled, ecnt == k+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  typedef struct {
    logic [31:0] addr;
    logic [23:0] led_in;
    logic [23:0] exp_led;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic goto_edge(input int target);
    int guard = 0;
    while (ecnt < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    n_assert++;
    if (ecnt != target) begin
      n_fail++;
      $display("FAIL goto_edge: at edge count %0d, wanted %0d", ecnt, target);
    end
  endtask

  // Checks led_out after each of edges first..first+n-1.
  task automatic check_win(input string name, input int first, input int n, input logic [23:0] exp);
    int bad = 0;
    int bad_edge = -1;
    logic [23:0] bad_val = '0;
    goto_edge(first + 1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (led_out !== exp) begin
        if (bad == 0) begin
          bad_edge = ecnt - 1;
          bad_val  = led_out;
        end
        bad++;
      end
    end
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d bad cycles, first at edge %0d got %h, expected %h",
               name, bad, bad_edge, bad_val, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    we    = 1'b1;
    wdata = d;
    @(negedge clk);
    we    = 1'b0;
    addr  = CADDR;
    wdata = 32'h0;
  endtask

  initial begin
    vecs[0] = '{CADDR,         24'hA5A5A5, 24'hA5A5A5, 32'h000000FF};
    vecs[1] = '{32'hFFFFF060,  24'h5A5A5A, 24'h5A5A5A, 32'h00000000};
    vecs[2] = '{CADDR,         24'h000001, 24'h000001, 32'h000000FF};
    vecs[3] = '{32'h00000000,  24'h800000, 24'h800000, 32'h00000000};
    vecs[4] = '{CADDR,         24'hFFFFFF, 24'hFFFFFF, 32'h000000FF};
    vecs[5] = '{32'hFFFFF065,  24'h123456, 24'h123456, 32'h00000000};

    rst_n  = 1'b0;
    addr   = CADDR;
    we     = 1'b0;
    wdata  = 32'h0;
    led_in = 24'hA5A5A5;

    // Reset state and pass-through
    repeat (3) @(negedge clk);
    chk("rst_led_out", {8'h0, led_out}, 32'h0);
    chk("rst_rdata", rdata, 32'h000000FF);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      addr   = vecs[i].addr;
      led_in = vecs[i].led_in;
      @(negedge clk);
      chk($sformatf("pass_led[%0d]", i), {8'h0, led_out}, {8'h0, vecs[i].exp_led});
      chk($sformatf("pass_rdata[%0d]", i), rdata, vecs[i].exp_rdata);
    end
    addr   = CADDR;
    led_in = ALL;

    // 25% duty, applied from the next period
    goto_edge(10);
    bus_write(CADDR, 32'h00000040);
    chk("rd_duty40", rdata, 32'h00000040);
    check_win("t2_hold", 11, 501, ALL);
    check_win("t2_on", 512, 128, ALL);
    check_win("t2_off", 640, 384, 24'h0);
    check_win("t2_on2", 1024, 128, ALL);
    check_win("t2_off2", 1152, 384, 24'h0);

    // Duty 0 mid-period, then back to full
    check_win("t3_on", 1536, 64, ALL);
    bus_write(CADDR, 32'h00000000);
    check_win("t3_tail_on", 1601, 63, ALL);
    check_win("t3_tail_off", 1664, 384, 24'h0);
    check_win("t3_zero", 2048, 152, 24'h0);
    bus_write(CADDR, 32'h000000FF);
    check_win("t3_zero2", 2201, 359, 24'h0);
    check_win("t3_full", 2560, 140, ALL);

    // Blink with half_period 2, then 0 (behaves as 1)
    bus_write(CADDR, 32'h000201FF);
    check_win("t4_pre", 2701, 371, ALL);
    check_win("t4_on", 3072, 1024, ALL);
    check_win("t4_off", 4096, 1024, 24'h0);
    check_win("t4_on2", 5120, 80, ALL);
    bus_write(CADDR, 32'h000001FF);
    check_win("t4_on3", 5201, 943, ALL);
    check_win("t4_alt_off", 6144, 512, 24'h0);
    check_win("t4_alt_on", 6656, 512, ALL);
    check_win("t4_alt_off2", 7168, 100, 24'h0);

    // Stores that must not touch ctrl
    bus_write(32'hFFFFF060, 32'h12345678);
    addr  = CADDR;
    we    = 1'b0;
    wdata = 32'hFFFFFFFF;
    @(negedge clk);
    @(negedge clk);
    wdata = 32'h0;
    chk("t5_rd_unchanged", rdata, 32'h000001FF);
    addr = 32'hFFFFF060;
    #1;
    chk("t5_rd_other", rdata, 32'h0);
    addr = CADDR;

    // Reset during blink off-phase
    chk("t6_pre_off", {8'h0, led_out}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_led", {8'h0, led_out}, 32'h0);
    chk("t6_rst_rdata", rdata, 32'h000000FF);
    led_in = 24'h3C3C3C;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_follow", {8'h0, led_out}, 32'h003C3C3C);
    led_in = 24'hC3C3C3;
    @(negedge clk);
    chk("t6_follow2", {8'h0, led_out}, 32'h00C3C3C3);

    // Masked write readback
    bus_write(CADDR, 32'hFFFFFFFF);
    chk("t5_rd_masked", rdata, 32'h00FF01FF);

    // Asynchronous reset while lit
    chk("t6_lit", {8'h0, led_out}, 32'h00C3C3C3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_led", {8'h0, led_out}, 32'h0);
    chk("t6_async_rdata", rdata, 32'h000000FF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_after", {8'h0, led_out}, 32'h00C3C3C3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
- Output stage directly downstream of the memory-mapped LED register: takes its 24-bit pattern and drives the board LED pins.
- Adds global brightness, an 8-bit PWM duty, and an optional blink, both set by a second MMIO control register at 0xFFFFF064.
- Reset default is full duty with blink off, so the board LEDs show the pattern exactly as written (one-cycle delay), as before this block.

Parameters:
- CTRL_ADDR, 32'hFFFFF064, byte address of the control register.
- PRESCALE, 4, clk cycles per PWM tick (>=1). PWM period = 256*PRESCALE cycles.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- addr  in  32  CPU data-bus address.
- we  in  1  CPU store strobe.
- wdata  in  32  CPU store data.
- led_in  in  24  pattern from the LED register.
- rdata  out  32  control-register readback (combinational).
- led_out  out  24  registered pins to the board LEDs.

Behaviour:
- ctrl register layout: [7:0] duty, [8] blink_en, [23:16] half_period (in PWM periods). All other bits are write-ignored and read as 0.
- Write: if we && addr==CTRL_ADDR at a clock edge, ctrl takes the masked wdata. Any other address leaves ctrl unchanged.
- rdata = (addr==CTRL_ADDR) ? masked ctrl : 32'h0. No read strobe.
- Timebase:
  - Prescaler runs 0..PRESCALE-1. tick is high in the cycle where it equals PRESCALE-1; the prescaler then wraps to 0.
  - pwm_cnt is 8 bits and increments on tick, wrapping 255->0.
  - period_end = tick && pwm_cnt==255.
- Shadow: duty_act, blink_en_act and half_act load from ctrl only on period_end. A ctrl write takes effect at the start of the next PWM period, which keeps the PWM glitch-free. If a write and period_end occur in the same cycle, the shadow loads the pre-write ctrl value; the new value applies one period later.
- pwm_on:
  - duty_act==0: 0.
  - duty_act==255: 1 (truly always on).
  - otherwise: pwm_cnt < duty_act.
- Blink:
  - blink_en_act==0: phase forced to 1 and blink_cnt forced to 0.
  - blink_en_act==1: on each period_end, if blink_cnt+1 >= max(half_act,1), phase toggles and blink_cnt clears; else blink_cnt increments. half_period 0 behaves as 1.
  - Phase is 1 on entry to blink mode.
- Output: led_out <= (pwm_on && phase) ? led_in : 24'h0. One-cycle latency from led_in or pwm state.
- Reset (asserted at any time, including mid-period or mid-blink):
  - led_out=0; prescaler, pwm_cnt and blink_cnt = 0; phase = 1.
  - ctrl = 32'h000000FF; shadow = duty 255, blink off.
  - rdata depends only on addr and ctrl.
- No other state. Counter widths: prescaler $clog2(PRESCALE) (min 1), blink_cnt 8 bits.

Decomposition:
- Shared package (alongside the other MMIO address constants): LED_PWM_CTRL_ADDR, field positions/widths DUTY_LSB/DUTY_W, BLINK_EN_BIT, HALF_LSB/HALF_W, CTRL_RST=32'h000000FF, CTRL_MASK=32'h00FF01FF.
- One natural sub-module, led_pwm_timebase: prescaler plus pwm_cnt, outputs pwm_cnt[7:0] and period_end.
- Register, shadow, blink and output logic stay in led_pwm_ctrl.

Test Plan (PRESCALE=2, period 512 cycles):
1. Hold rst_n=0 -> led_out=0, rdata@0xFFFFF064=0x000000FF. Release, led_in=0xA5A5A5 -> led_out=0xA5A5A5 one cycle later, and it tracks led_in changes with 1-cycle latency.
2. Write 0x00000040, led_in=0xFFFFFF -> unchanged until the current period ends. Each later period: led_out=0xFFFFFF for exactly 128 cycles, then 0 for 384 cycles.
3. Write 0x00000000 mid-period -> full-on continues to period end, then led_out stays 0. Write 0x000000FF -> full-on resumes from the next period with no off cycles.
4. Write 0x000201FF -> from the next period: on 2 periods (1024 cycles), off 2 periods, repeating. Write 0x000001FF -> alternates every period.
5. Store 0x12345678 to 0xFFFFF060, and a store to CTRL_ADDR with we=0 -> ctrl unchanged. Write 0xFFFFFFFF -> rdata reads 0x00FF01FF.
6. Assert rst_n low during a blink off-phase -> led_out=0 immediately. After release, ctrl=0xFF and led_out follows led_in.
